puf_parallel_sampler: RTL and testbench

PUF_PARALLEL_SAMPLER -- requirements
Module: puf_parallel_sampler

---
 rtl/puf_parallel_sampler.sv | 188 ++++++++++++++++++
 tb/tb_puf_parallel_sampler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/puf_parallel_sampler.sv
// ============================================================================
// Module   : puf_parallel_sampler
// Purpose  : Majority-vote sampler for a parallel array of race-arbiter PUFs.
// Optional : PUF_SAMPLER_STABILITY_EN adds per-channel disagreement flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module puf_parallel_sampler #(
    parameter int NUM_CH     = 8,
    parameter int CHAL_W     = 8,
    parameter int EN_W       = 32,
    parameter int SETTLE_CYC = 4,
    parameter int VOTE_N     = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge,
    input  logic [EN_W-1:0]   enable,
    output logic              busy,
    output logic [CHAL_W-1:0] puf_challenge,
    output logic [EN_W-1:0]   puf_enable,
    output logic              race_go,
    input  logic [NUM_CH-1:0] arb_in,
    output logic [NUM_CH-1:0] resp,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [NUM_CH-1:0] unstable
);

    localparam int CNT_W = $clog2(VOTE_N + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [CNT_W-1:0] VOTE_LAST   = CNT_W'(VOTE_N - 1);
    localparam logic [CNT_W-1:0] VOTE_HALF   = CNT_W'(VOTE_N / 2);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    if ((VOTE_N < 1) || ((VOTE_N % 2) == 0)) begin : g_bad_vote_n
        $error("puf_parallel_sampler: VOTE_N must be odd and >= 1");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("puf_parallel_sampler: SETTLE_CYC must be >= 1");
    end

    logic [2:0]        state_q, state_d;
    logic [CHAL_W-1:0] chal_q, chal_d;
    logic [EN_W-1:0]   en_q, en_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  round_q, round_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [NUM_CH-1:0] resp_q, resp_d;
    logic              valid_q, valid_d;
    logic              last_round;

    assign last_round = (round_q == VOTE_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ARM;
            S_ARM:    state_d = S_SETTLE;
            S_SETTLE: if (settle_q == SETTLE_LAST) state_d = S_SAMPLE;
            S_SAMPLE: state_d = last_round ? S_DONE : S_ARM;
            S_DONE:   if (resp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        race_go = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    end

    // Responses are decided from the post-increment counts so they land on DONE entry.
    always_comb begin
        chal_d   = chal_q;
        en_d     = en_q;
        cnt_d    = cnt_q;
        round_d  = round_q;
        settle_d = settle_q;
        resp_d   = resp_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    en_d    = enable;
                    round_d = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        cnt_d[i] = '0;
                    end
                end
            end
            S_ARM:    settle_d = '0;
            S_SETTLE: settle_d = settle_q + SET_W'(1);
            S_SAMPLE: begin
                round_d = round_q + CNT_W'(1);
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(arb_in[i]);
                end
                if (last_round) begin
                    valid_d = 1'b1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        resp_d[i] = (cnt_d[i] > VOTE_HALF);
                    end
                end
            end
            S_DONE:   if (resp_ready) valid_d = 1'b0;
            default:  valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            chal_q   <= '0;
            en_q     <= '0;
            round_q  <= '0;
            settle_q <= '0;
            resp_q   <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            chal_q   <= chal_d;
            en_q     <= en_d;
            round_q  <= round_d;
            settle_q <= settle_d;
            resp_q   <= resp_d;
            valid_q  <= valid_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign puf_challenge = chal_q;
    assign puf_enable    = en_q;
    assign resp          = resp_q;
    assign resp_valid    = valid_q;

`ifdef PUF_SAMPLER_STABILITY_EN
    localparam logic [CNT_W-1:0] VOTE_MAX = CNT_W'(VOTE_N);

    logic [NUM_CH-1:0] unstable_q, unstable_d;

    // A channel is unstable when its votes were neither unanimous 0 nor unanimous 1.
    always_comb begin
        unstable_d = unstable_q;
        if ((state_q == S_SAMPLE) && last_round) begin
            for (int i = 0; i < NUM_CH; i++) begin
                unstable_d[i] = (cnt_d[i] != '0) && (cnt_d[i] != VOTE_MAX);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            unstable_q <= '0;
        end else begin
            unstable_q <= unstable_d;
        end
    end

    assign unstable = unstable_q;
`else
    assign unstable = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_puf_parallel_sampler.sv
// ============================================================================
// Module   : tb_puf_parallel_sampler
// Purpose  : Directed self-checking bench; default instance plus a
//            NUM_CH=16 / VOTE_N=5 / SETTLE_CYC=1 instance.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_puf_parallel_sampler;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic        start_a, ready_a, busy_a, go_a, valid_a;
    logic [7:0]  chal_a, pchal_a, arb_a, resp_a, unst_a;
    logic [31:0] en_a, pen_a;

    logic        start_b, ready_b, busy_b, go_b, valid_b;
    logic [7:0]  chal_b, pchal_b;
    logic [15:0] arb_b, resp_b, unst_b;
    logic [31:0] en_b, pen_b;

    puf_parallel_sampler u_dut_a (
        .clock(clock), .reset(reset), .start(start_a), .challenge(chal_a),
        .enable(en_a), .busy(busy_a), .puf_challenge(pchal_a), .puf_enable(pen_a),
        .race_go(go_a), .arb_in(arb_a), .resp(resp_a), .resp_valid(valid_a),
        .resp_ready(ready_a), .unstable(unst_a)
    );

    puf_parallel_sampler #(.NUM_CH(16), .VOTE_N(5), .SETTLE_CYC(1)) u_dut_b (
        .clock(clock), .reset(reset), .start(start_b), .challenge(chal_b),
        .enable(en_b), .busy(busy_b), .puf_challenge(pchal_b), .puf_enable(pen_b),
        .race_go(go_b), .arb_in(arb_b), .resp(resp_b), .resp_valid(valid_b),
        .resp_ready(ready_b), .unstable(unst_b)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Launch one evaluation, drive per-round arbiter values, check race_go
    // shape per round and the start-to-valid latency.
    task automatic run_eval(input bit big, input logic [4:0][15:0] rv,
                            input logic [7:0] chal, input logic [31:0] en, input string tag);
        int per, nv, k;
        logic [5:0] pat;
        logic v;
        per = big ? 3 : 6;
        nv  = big ? 5 : 3;
        if (big) begin
            chal_b = chal; en_b = en; arb_b = rv[0]; start_b = 1'b1;
        end else begin
            chal_a = chal; en_a = en; arb_a = rv[0][7:0]; start_a = 1'b1;
        end
        tick();
        start_a = 1'b0; start_b = 1'b0;
        chal_a = ~chal; en_a = ~en; chal_b = ~chal; en_b = ~en;
        k = 0;
        pat = '0;
        while (1) begin
            v = big ? valid_b : valid_a;
            if (v || k >= 100) break;
            if (k / per < nv) begin
                if (big) arb_b = rv[k / per];
                else     arb_a = rv[k / per][7:0];
                pat[k % per] = big ? go_b : go_a;
                if (k % per == per - 1) begin
                    chk($sformatf("%s race_go r%0d", tag, k / per), pat, big ? 6'h06 : 6'h3E);
                    pat = '0;
                end
            end
            tick();
            k++;
        end
        chk({tag, " latency"}, k, nv * per);
        chk({tag, " puf_challenge"}, big ? pchal_b : pchal_a, chal);
        chk({tag, " puf_enable"}, big ? pen_b : pen_a, en);
    endtask

    task automatic complete(input bit big, input string tag);
        if (big) ready_b = 1'b1; else ready_a = 1'b1;
        tick();
        ready_a = 1'b0; ready_b = 1'b0;
        chk({tag, " valid after xfer"}, big ? valid_b : valid_a, 1'b0);
        chk({tag, " busy after xfer"}, big ? busy_b : busy_a, 1'b0);
    endtask

    logic [4:0][15:0] rv;
    logic [7:0] exp_unst;
    int bad;

    initial begin
        reset = 1'b0;
        start_a = 0; ready_a = 0; chal_a = '0; en_a = '0; arb_a = '0;
        start_b = 0; ready_b = 0; chal_b = '0; en_b = '0; arb_b = '0;
        repeat (3) tick();
        chk("rst busy", busy_a, 1'b0);
        chk("rst race_go", go_a, 1'b0);
        chk("rst resp", resp_a, 8'h00);
        chk("rst valid", valid_a, 1'b0);
        chk("rst unstable", unst_a, 8'h00);
        chk("rst puf_challenge", pchal_a, 8'h00);
        chk("rst puf_enable", pen_a, 32'h0);
        chk("rst b busy", busy_b, 1'b0);
        chk("rst b valid", valid_b, 1'b0);
        reset = 1'b1;
        tick();

        rv = {16'h0, 16'h0, 16'h00A5, 16'h00A5, 16'h00A5};
        run_eval(1'b0, rv, 8'h3C, 32'hDEADBEEF, "t039");
        chk("t039 resp", resp_a, 8'hA5);
        chk("t039 unstable", unst_a, 8'h00);
        complete(1'b0, "t039");
        chk("t039 puf_challenge idle", pchal_a, 8'h3C);

        rv = {16'h0, 16'h0, 16'h0001, 16'h0000, 16'h0001};
        run_eval(1'b0, rv, 8'h11, 32'h0000FFFF, "t040");
        chk("t040 resp", resp_a, 8'h01);
`ifdef PUF_SAMPLER_STABILITY_EN
        exp_unst = 8'h01;
`else
        exp_unst = 8'h00;
`endif
        chk("t040 unstable", unst_a, exp_unst);

        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start_a = (i == 3);
            chal_a  = 8'hEE;
            tick();
            if (resp_a !== 8'h01 || valid_a !== 1'b1 || unst_a !== exp_unst || busy_a !== 1'b1)
                bad++;
        end
        start_a = 1'b0;
        chk("t041 hold stable", bad, 0);
        chk("t041 puf_challenge held", pchal_a, 8'h11);
        complete(1'b0, "t041");

        rv = {16'h0, 16'h0, 16'h003C, 16'h00F0, 16'h000F};
        run_eval(1'b0, rv, 8'h5A, 32'hCAFEF00D, "t041b");
        chk("t041b resp", resp_a, 8'h3C);
`ifdef PUF_SAMPLER_STABILITY_EN
        chk("t041b unstable", unst_a, 8'hFF);
`else
        chk("t041b unstable", unst_a, 8'h00);
`endif
        complete(1'b0, "t041b");

        chal_a = 8'h77; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (8) tick();
        reset = 1'b0;
        tick();
        chk("t042 busy", busy_a, 1'b0);
        chk("t042 race_go", go_a, 1'b0);
        chk("t042 valid", valid_a, 1'b0);
        chk("t042 resp", resp_a, 8'h00);
        chk("t042 puf_challenge", pchal_a, 8'h00);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (valid_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        chk("t042 no response", bad, 0);
        rv = {16'h0, 16'h0, 16'h005A, 16'h005A, 16'h005A};
        run_eval(1'b0, rv, 8'h42, 32'h0F0F0F0F, "t042b");
        chk("t042b resp", resp_a, 8'h5A);
        complete(1'b0, "t042b");

        rv = {16'h4001, 16'h0001, 16'h4001, 16'h8001, 16'hC001};
        run_eval(1'b1, rv, 8'h96, 32'h12345678, "t043");
        chk("t043 resp", resp_b, 16'h4001);
`ifdef PUF_SAMPLER_STABILITY_EN
        chk("t043 unstable", unst_b, 16'hC000);
`else
        chk("t043 unstable", unst_b, 16'h0000);
`endif
        complete(1'b1, "t043");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
